// File: rtl/pcpi_seq_pkg.sv
// Shared types and sizes for the PCPI host sequencer.
// Holds the sequencer state enum and frame/result/timeout widths.
package pcpi_seq_pkg;

    typedef enum logic [1:0] {
        LOAD,
        ISSUE,
        SEND_HI,
        SEND_LO
    } state_t;

    localparam int FRAME_NIBBLES  = 24;
    localparam int RESULT_NIBBLES = 8;
    localparam int TIMEOUT_W      = 8;
    localparam int IDX_W          = 5;
    localparam int K_W            = 3;

endpackage

// File: rtl/pcpi_nib_rx.sv
// Four-phase slave nibble receiver.
// Ports: clk, rst_n (sync, active-low), en gates new accepts,
//   nib_in/nib_req from sender, nib_ack back to sender,
//   acc is a 1-cycle accept strobe with data valid alongside it.
module pcpi_nib_rx (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] nib_in,
    input  logic       nib_req,
    output logic       nib_ack,
    output logic       acc,
    output logic [3:0] data
);

    assign acc  = en && nib_req && !nib_ack;
    assign data = nib_in;

    // Once raised, ack drops on req low even if en has gone away,
    // so the sender can always finish its handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            nib_ack <= 1'b0;
        end else if (acc) begin
            nib_ack <= 1'b1;
        end else if (!nib_req) begin
            nib_ack <= 1'b0;
        end
    end

endmodule

// File: rtl/pcpi_host_sequencer.sv
// Runs one PCPI transaction: 24-nibble command frame in, request with
// timeout, 8-nibble result out. Ports: nibble rx handshake (nib_*),
// result tx handshake (res_*), PCPI master (pcpi_*), busy and error flags.
module pcpi_host_sequencer
    import pcpi_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  nib_in,
    input  logic        nib_req,
    output logic        nib_ack,
    output logic [3:0]  res_nib,
    output logic        res_req,
    input  logic        res_ack,
    output logic        pcpi_valid,
    output logic [31:0] pcpi_insn,
    output logic [31:0] pcpi_rs1,
    output logic [31:0] pcpi_rs2,
    input  logic        pcpi_wr,
    input  logic [31:0] pcpi_rd,
    input  logic        pcpi_wait,
    input  logic        pcpi_ready,
    output logic        busy,
    output logic        err_timeout,
    output logic        err_nowr
);

    localparam logic [TIMEOUT_W-1:0] TMO = TIMEOUT_W'(TIMEOUT_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_NIBBLES - 1);
    localparam logic [K_W-1:0] LAST_K = K_W'(RESULT_NIBBLES - 1);

    state_t                     state;
    state_t                     state_next;
    logic [IDX_W-1:0]           idx;
    logic                       full;
    logic [4*FRAME_NIBBLES-1:0] frame;
    logic [31:0]                result;
    logic [K_W-1:0]             k;
    logic [TIMEOUT_W-1:0]       cnt;
    logic [TIMEOUT_W-1:0]       cnt_next;
    logic                       timeout_hit;
    logic                       rx_en;
    logic                       rx_acc;
    logic [3:0]                 rx_data;

    // full marks slot 23 taken; idx saturates there.
    assign rx_en = (state == LOAD) && !full;

    pcpi_nib_rx u_rx (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (rx_en),
        .nib_in  (nib_in),
        .nib_req (nib_req),
        .nib_ack (nib_ack),
        .acc     (rx_acc),
        .data    (rx_data)
    );

    assign cnt_next    = pcpi_wait ? '0 : cnt + 8'd1;
    assign timeout_hit = (cnt_next == TMO);

    assign pcpi_valid = (state == ISSUE);
    assign pcpi_insn  = frame[31:0];
    assign pcpi_rs1   = frame[63:32];
    assign pcpi_rs2   = frame[95:64];
    assign res_req    = (state == SEND_HI);
    assign res_nib    = (state == SEND_HI || state == SEND_LO)
                      ? result[4*k +: 4] : 4'h0;
    assign busy       = (state != LOAD) || (idx != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            LOAD: begin
                if (full && !nib_ack) state_next = ISSUE;
            end
            ISSUE: begin
                if (pcpi_ready || timeout_hit) state_next = SEND_HI;
            end
            SEND_HI: begin
                if (res_ack) state_next = SEND_LO;
            end
            SEND_LO: begin
                if (!res_ack) state_next = (k == LAST_K) ? LOAD : SEND_HI;
            end
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx         <= '0;
            full        <= 1'b0;
            frame       <= '0;
            result      <= '0;
            k           <= '0;
            cnt         <= '0;
            err_timeout <= 1'b0;
            err_nowr    <= 1'b0;
        end else begin
            if (rx_acc) begin
                frame[4*idx +: 4] <= rx_data;
                if (idx == LAST_IDX) full <= 1'b1;
                else                 idx  <= idx + 5'd1;
                if (idx == '0) begin
                    err_timeout <= 1'b0;
                    err_nowr    <= 1'b0;
                end
            end
            unique case (state)
                LOAD: cnt <= '0;
                ISSUE: begin
                    cnt <= cnt_next;
                    // ready has priority over a coincident timeout
                    if (pcpi_ready) begin
                        result   <= pcpi_wr ? pcpi_rd : 32'h0;
                        err_nowr <= ~pcpi_wr;
                    end else if (timeout_hit) begin
                        result      <= 32'h0;
                        err_timeout <= 1'b1;
                    end
                end
                SEND_LO: begin
                    if (!res_ack) begin
                        if (k == LAST_K) begin
                            k    <= '0;
                            idx  <= '0;
                            full <= 1'b0;
                        end else begin
                            k <= k + 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pcpi_host_sequencer.sv
// Directed self-checking bench for pcpi_host_sequencer.
// Drives frames, a scripted coprocessor and the result host.
module tb_pcpi_host_sequencer;

    logic        clk;
    logic        rst_n;
    logic [3:0]  nib_in;
    logic        nib_req;
    logic        nib_ack;
    logic [3:0]  res_nib;
    logic        res_req;
    logic        res_ack;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic [31:0] pcpi_rs1;
    logic [31:0] pcpi_rs2;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        pcpi_wait;
    logic        pcpi_ready;
    logic        busy;
    logic        err_timeout;
    logic        err_nowr;

    int compared = 0;
    int mismatched = 0;

    pcpi_host_sequencer #(.TIMEOUT_CYCLES(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .nib_in      (nib_in),
        .nib_req     (nib_req),
        .nib_ack     (nib_ack),
        .res_nib     (res_nib),
        .res_req     (res_req),
        .res_ack     (res_ack),
        .pcpi_valid  (pcpi_valid),
        .pcpi_insn   (pcpi_insn),
        .pcpi_rs1    (pcpi_rs1),
        .pcpi_rs2    (pcpi_rs2),
        .pcpi_wr     (pcpi_wr),
        .pcpi_rd     (pcpi_rd),
        .pcpi_wait   (pcpi_wait),
        .pcpi_ready  (pcpi_ready),
        .busy        (busy),
        .err_timeout (err_timeout),
        .err_nowr    (err_nowr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_nib(input logic [3:0] n);
        nib_in  = n;
        nib_req = 1'b1;
        for (int c = 0; c < 20 && !nib_ack; c++) tick();
        if (!nib_ack) chk("nib_ack_rise_timeout", nib_ack, 1);
        nib_req = 1'b0;
        for (int c = 0; c < 20 && nib_ack; c++) tick();
        if (nib_ack) chk("nib_ack_fall_timeout", nib_ack, 0);
    endtask

    task automatic send_slots(input logic [95:0] f, input int from);
        for (int i = from; i < 24; i++) send_nib(f[4*i +: 4]);
    endtask

    task automatic recv_result(input logic [31:0] exp);
        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c < 50 && !res_req; c++) tick();
            if (!res_req) chk("res_req_rise_timeout", res_req, 1);
            chk($sformatf("res_nib%0d", i), res_nib, exp[4*i +: 4]);
            res_ack = 1'b1;
            for (int c = 0; c < 50 && res_req; c++) tick();
            if (res_req) chk("res_req_fall_timeout", res_req, 0);
            res_ack = 1'b0;
        end
        tick();
    endtask

    initial begin
        int vcnt;
        logic stable;
        logic ack_seen;

        rst_n = 0; nib_in = 0; nib_req = 0; res_ack = 0;
        pcpi_wr = 0; pcpi_rd = 0; pcpi_wait = 0; pcpi_ready = 0;
        tick(); tick();
        chk("rst_ctl", {24'h0, nib_ack, res_req, pcpi_valid, busy,
            err_timeout, err_nowr, res_nib[3:2]}, 32'h0);
        chk("rst_nib", {28'h0, res_nib}, 32'h0);
        chk("rst_ops", pcpi_insn | pcpi_rs1 | pcpi_rs2, 32'h0);
        rst_n = 1;
        tick();

        // Frame 1: exact ack latency, then wait x5 and ready wr=1
        nib_in = 4'hB; nib_req = 1'b1;
        tick();
        chk("ack_latency", nib_ack, 1);
        chk("busy_loading", busy, 1);
        nib_req = 1'b0;
        tick();
        chk("ack_fall", nib_ack, 0);
        send_slots({32'h9ABC_DEF0, 32'h1234_5678, 32'h0000_300B}, 1);
        chk("valid_not_yet", pcpi_valid, 0);
        tick();
        chk("valid_rise", pcpi_valid, 1);
        chk("insn", pcpi_insn, 32'h0000_300B);
        chk("rs1", pcpi_rs1, 32'h1234_5678);
        chk("rs2", pcpi_rs2, 32'h9ABC_DEF0);
        pcpi_wait = 1;
        repeat (5) tick();
        chk("valid_waiting", pcpi_valid, 1);
        pcpi_wait = 0; pcpi_ready = 1; pcpi_wr = 1;
        pcpi_rd = 32'hCAFE_F00D;
        tick();
        pcpi_ready = 0; pcpi_rd = 32'hFFFF_FFFF;
        chk("valid_fall", pcpi_valid, 0);
        chk("res_req_rise", res_req, 1);
        recv_result(32'hCAFE_F00D);
        chk("f1_errs", {err_timeout, err_nowr}, 0);
        chk("f1_idle", busy, 0);

        // Frame 2: silent coprocessor, timeout at 16
        send_slots({32'h0, 32'h0, 32'h0000_300B}, 0);
        tick();
        vcnt = 0;
        for (int c = 0; c < 300 && pcpi_valid; c++) begin
            vcnt++;
            tick();
        end
        chk("timeout_valid_cycles", vcnt, 16);
        recv_result(32'h0);
        chk("timeout_err", {err_timeout, err_nowr}, 2'b10);

        // Frame 3: first nibble clears errors, earliest ready wr=0
        send_nib(4'hB);
        chk("err_cleared", err_timeout, 0);
        send_slots({32'h2, 32'h1, 32'h0200_300B}, 1);
        tick();
        chk("f3_valid", pcpi_valid, 1);
        pcpi_ready = 1; pcpi_wr = 0; pcpi_rd = 32'hFFFF_FFFF;
        tick();
        pcpi_ready = 0;
        chk("f3_min_latency", {pcpi_valid, res_req}, 2'b01);
        recv_result(32'h0);
        chk("nowr_err", {err_timeout, err_nowr}, 2'b01);

        // Reset mid-frame and mid-ISSUE
        send_slots({32'h0, 32'h0, 32'hFFFF_FFFF}, 13);
        rst_n = 0;
        tick();
        chk("rst_load_ctl", {nib_ack, busy, pcpi_valid}, 0);
        chk("rst_load_insn", pcpi_insn, 32'h0);
        rst_n = 1;
        tick();
        send_slots({32'h5, 32'h6, 32'h7}, 0);
        tick();
        chk("rst_issue_pre", pcpi_valid, 1);
        rst_n = 0;
        tick();
        chk("rst_issue_ctl", {pcpi_valid, busy, res_req}, 0);
        chk("rst_issue_rs1", pcpi_rs1, 32'h0);
        rst_n = 1;
        tick();
        send_slots({32'hA5A5_0001, 32'h0F0F_1234, 32'h0000_300B}, 0);
        tick();
        chk("fresh_rs2", pcpi_rs2, 32'hA5A5_0001);
        pcpi_ready = 1; pcpi_wr = 1; pcpi_rd = 32'h1357_9BDF;
        tick();
        pcpi_ready = 0;
        recv_result(32'h1357_9BDF);
        chk("fresh_errs", {err_timeout, err_nowr, busy}, 0);

        // Stalled host during SEND_HI, nib_req pulses ignored
        send_slots({32'h0, 32'h0, 32'h0000_300B}, 0);
        tick();
        pcpi_ready = 1; pcpi_wr = 1; pcpi_rd = 32'h8421_0F5A;
        tick();
        pcpi_ready = 0;
        stable = 1'b1;
        ack_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            nib_req = ((i % 4) < 2);
            tick();
            if (res_req !== 1'b1 || res_nib !== 4'hA) stable = 1'b0;
            if (nib_ack !== 1'b0) ack_seen = 1'b1;
        end
        nib_req = 1'b0;
        chk("hold_stable", stable, 1);
        chk("send_no_ack", ack_seen, 0);
        recv_result(32'h8421_0F5A);
        chk("end_idle", {busy, nib_ack}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pcpi_host_sequencer.md
# pcpi_host_sequencer

Sequences one coprocessor transaction on the PCPI port from the narrow chip pins. It collects a 96-bit command frame (insn, rs1, rs2) as 24 nibbles over a four-phase handshake, then drives the PCPI request and waits for completion with a timeout. It returns the 32-bit result as 8 nibbles over a second four-phase handshake. It sits between the tt_um top-level pin mapping and the matrix-multiply PCPI unit, replacing the ad-hoc nibble latch in the top level.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: consecutive cycles with neither pcpi_wait nor pcpi_ready before the request is abandoned (1..255).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- nib_in  in  4  command nibble
- nib_req  in  1  sender request (four-phase)
- nib_ack  out  1  receive acknowledge
- res_nib  out  4  result nibble
- res_req  out  1  result request (four-phase master)
- res_ack  in  1  result acknowledge from host
- pcpi_valid  out  1  request valid
- pcpi_insn  out  32  instruction
- pcpi_rs1  out  32  operand 1
- pcpi_rs2  out  32  operand 2
- pcpi_wr  in  1  coprocessor writes rd
- pcpi_rd  in  32  coprocessor result
- pcpi_wait  in  1  coprocessor busy
- pcpi_ready  in  1  coprocessor done
- busy  out  1  frame in progress or transaction outstanding
- err_timeout  out  1  last transaction timed out
- err_nowr  out  1  last transaction completed with pcpi_wr=0

All inputs are synchronous to clk. Pin synchronisation is done at top level.

## Operation
- States: LOAD, ISSUE, SEND_HI, SEND_LO.
- LOAD, receive:
  - When nib_req=1 and nib_ack=0, write nib_in into frame slot idx (0..23), increment idx, and set nib_ack=1.
  - nib_ack holds 1 until nib_req=0, then clears.
  - Slot order: insn nibbles 0–7, rs1 8–15, rs2 16–23, each least-significant nibble first.
  - The first accepted nibble (idx=0) clears err_timeout and err_nowr.
- Leaving LOAD: when slot 23 is accepted, move to ISSUE on the next cycle, once nib_ack has dropped. Frame registers drive pcpi_insn/rs1/rs2 directly.
- ISSUE:
  - pcpi_valid=1, held until exit.
  - Timeout counter clears on any cycle with pcpi_wait=1 and increments otherwise.
  - On pcpi_ready=1: result = pcpi_wr ? pcpi_rd : 0; err_nowr = ~pcpi_wr; go to SEND_HI.
  - When the counter reaches TIMEOUT_CYCLES: result = 0; err_timeout=1; go to SEND_HI.
  - pcpi_ready and timeout in the same cycle: ready wins.
- SEND_HI: drive res_nib = result[4k+3:4k] and res_req=1. When res_ack=1, go to SEND_LO.
- SEND_LO: res_req=0, res_nib held. When res_ack=0, advance k.
  - k<7: return to SEND_HI.
  - k=7: go to LOAD with idx=0.
- Ignored inputs:
  - pcpi_ready/pcpi_wait outside ISSUE.
  - nib_req outside LOAD; nib_ack stays 0.
- busy=1 when state≠LOAD or idx≠0.

## Timing
- Reset values:
  - State LOAD; idx=0; k=0.
  - All outputs 0: nib_ack, res_req, res_nib, pcpi_valid, pcpi_insn/rs1/rs2, busy, err_timeout, err_nowr.
  - Result register 0.
- Reset mid-transaction (any state) aborts immediately. pcpi_valid drops the cycle after rst_n is sampled low.
- nib_ack rises 1 cycle after nib_req is sampled high and falls 1 cycle after nib_req is sampled low.
- pcpi_valid rises 1 cycle after the slot-23 nib_ack falls.
- pcpi_valid falls 1 cycle after pcpi_ready is sampled. res_req rises in that same cycle.
- Earliest ready (same cycle pcpi_valid first high) is accepted. Minimum issue latency is 1 cycle.
- Timeout: with pcpi_wait=0 throughout, exit occurs TIMEOUT_CYCLES cycles after pcpi_valid rises.
- Counter widths: idx 5 bits, saturating at 23. Timeout counter 8 bits, no wrap.

## Structure
- Package pcpi_seq_pkg:
  - state enum (LOAD, ISSUE, SEND_HI, SEND_LO).
  - FRAME_NIBBLES=24, RESULT_NIBBLES=8, TIMEOUT_W=8.
- Sub-module pcpi_nib_rx: four-phase slave nibble receiver producing a 1-cycle accept strobe and data. Instantiated once. The result sender is simple enough to stay inline.

## Test plan
- Send frame insn=0x0000_300B, rs1=0x1234_5678, rs2=0x9ABC_DEF0. Check pcpi_* equal those values with pcpi_valid=1.
- Model returns pcpi_wait 5 cycles, then ready with wr=1, rd=0xCAFE_F00D. Check res_nib sequence D,0,0,F,E,F,A,C and err_*=0.
- Coprocessor silent, TIMEOUT_CYCLES=16. Check pcpi_valid high exactly 16 cycles, 8 result nibbles all 0, err_timeout=1, then cleared by the next frame's first nibble.
- Ready with wr=0. Check result nibbles all 0 and err_nowr=1.
- Pulse rst_n low after nibble 10, then after ISSUE entry. Check all outputs return to 0, and that a fresh 24-nibble frame then completes normally.
- Hold res_ack low 20 cycles during SEND_HI. Check res_req and res_nib are stable, and that nib_req pulses are not acknowledged during SEND.
